md_unit: RTL
============

# md_unit

Multiply/divide unit with its sequencing controller, placed in the E stage beside the ALU. It accepts one HI/LO-class operation per start pulse. Multi-cycle operations raise `busy` for a fixed latency, and each operation commits its result to the architectural HI/LO registers in a single cycle. The hazard unit stalls any HI/LO-class instruction in D while `busy` is high or `start` is high; this block does not stall anything itself.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu/madd/maddu/msub/msubu. Range 1..15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu. Range 1..15.

- `clk`  in  1  single clock, all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; evaluated at the rising edge and overrides every other input.
- `start`  in  1  launches the operation given on `md_op` this cycle.
- `md_op`  in  4  operation select:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
  - 7 madd, 8 maddu, 9 msub, 10 msubu.
  - 11..15 reserved, treated as none.
- `A`  in  32  rs operand (forwarded value).
- `B`  in  32  rt operand (forwarded value).
- `busy`  out  1  a multi-cycle operation is in flight.
- `HI`  out  32  architectural HI, read by mfhi.
- `LO`  out  32  architectural LO, read by mflo.

## Operation
- State: `IDLE` / `RUN`, plus a 4-bit down-counter `cnt`, and 32-bit pending registers `pend_hi` and `pend_lo`.
- Reset: `HI`=0, `LO`=0, `cnt`=0, state `IDLE`, `busy`=0, pending registers 0.
- Accepting a start: `start` is accepted only in `IDLE`. In `RUN`, `start` and `md_op` are ignored entirely, with no effect on HI/LO or on the counter.
- mthi/mtlo on acceptance: `HI`<=`A` (or `LO`<=`A`) at that edge. State stays `IDLE` and `busy` stays 0.
- Multi-cycle ops on acceptance: compute the result from `A`, `B` and the current `{HI,LO}`, latch it into `pend_hi:pend_lo`, load `cnt` with `MULT_CYCLES` or `DIV_CYCLES`, and go to `RUN`.
- `RUN`: `cnt` decrements every cycle. On the edge where `cnt` goes 1->0:
  - `HI`<=`pend_hi` and `LO`<=`pend_lo`;
  - state returns to `IDLE`.
- `busy` = (state == `RUN`), driven combinationally from the state register.
- Arithmetic (all 64-bit results wrap modulo 2^64):
  - mult: signed 32x32->64. multu: unsigned.
  - madd/msub: `{HI,LO}` +/- signed product. maddu/msubu: same with the unsigned product.
  - div/divu: LO = quotient, HI = remainder. Signed quotient truncates toward zero; signed remainder takes the sign of the dividend.
  - div of 0x80000000 by -1: LO=0x80000000, HI=0.
  - Divisor 0 (div or divu): full `DIV_CYCLES` busy, then commit with HI/LO unchanged. `pend_*` are loaded with the current HI/LO.
- Operands and the accumulator value are captured at acceptance. Later changes to `A`/`B` have no effect. The accumulate result is fixed at start; a mthi/mtlo cannot intervene because it is ignored while in `RUN`.
- Reset mid-operation: the operation is aborted with no commit, and HI/LO go to 0.

## Timing
- Start of a multi-cycle op accepted at edge k:
  - `busy`=1 from after edge k through edge k+N (N = the op's cycle count);
  - HI/LO take the new value at edge k+N;
  - `busy` falls at that same edge.
- Back-to-back: a `start` presented in the cycle after edge k+N is accepted. A `start` presented in the same cycle as the commit edge is still in `RUN` and is ignored.
- mthi/mtlo: latency 1 (visible after the accepting edge), throughput 1 per cycle.
- HI/LO are registered outputs; there is no combinational path from `A`/`B` to HI/LO.

## Test plan
- Reset, then mult with `A`=0xFFFFFFFE (-2), `B`=3 -> `busy` high for exactly 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA at the 5th edge.
- multu with `A`=0xFFFFFFFF, `B`=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div with `A`=-7 (0xFFFFFFF9), `B`=2 -> after 10 busy cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then divu with `A`=7, `B`=0 -> busy for 10 cycles, HI/LO unchanged.
- Sequence mthi 0, then mtlo 0xFFFFFFFF (HI/LO visible the edge after each), then maddu `A`=1, `B`=1 -> HI=1, LO=0.
- Then msub `A`=1, `B`=2 with HI=1, LO=0 -> HI=0, LO=0xFFFFFFFE.
- During a mult in `RUN`, pulse mtlo `A`=0x1234 and pulse start/div -> both ignored, mult result commits on schedule. Separately, assert `reset` at busy cycle 3 -> `busy`=0, HI=LO=0 next cycle, and no later commit occurs.

Source files
------------

// File: rtl/md_unit_if.sv
// Multiply/divide unit port bundle.
//   start      : launch the operation on md_op this cycle (accepted only when idle)
//   md_op      : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                7 madd, 8 maddu, 9 msub, 10 msubu, 11..15 none
//   A, B       : rs / rt operands
//   busy       : a multi-cycle operation is in flight
//   HI, LO     : architectural HI/LO registers
//   dbg_state  : controller state (0 IDLE, 1 RUN) for observation
//
// Handshake: the unit samples start/md_op/A/B at a rising edge only while
// busy is low; while busy is high start is ignored and never back-pressured
// or queued. Results appear on HI/LO at the edge where busy falls.
interface md_unit_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        dbg_state;

    modport master (
        output start, md_op, A, B,
        input  busy, HI, LO, dbg_state
    );

    modport slave (
        input  start, md_op, A, B,
        output busy, HI, LO, dbg_state
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: HI/LO multiply/divide unit with its sequencing controller.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset; aborts any in-flight operation
//   md      : md_unit_if.slave bundle (start, md_op, A, B, busy, HI, LO, dbg_state)
// Multi-cycle results are computed at acceptance, parked in pend_hi/pend_lo,
// and committed to HI/LO in one cycle when the down-counter expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Arithmetic datapath, evaluated on the live operands and accumulator.
    logic [63:0] acc;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a, abs_b, mag_q, mag_r;
    logic [31:0] div_q_s, div_r_s, div_q_u, div_r_u;
    logic [31:0] divisor_u;

    always_comb begin
        acc    = {hi_q, lo_q};
        prod_s = $signed(md.A) * $signed(md.B);
        prod_u = {32'b0, md.A} * {32'b0, md.B};

        // Divisor zero results are discarded; substitute 1 so no X/trap arises.
        divisor_u = (md.B == 32'd0) ? 32'd1 : md.B;
        div_q_u   = md.A / divisor_u;
        div_r_u   = md.A % divisor_u;

        // Signed divide through magnitudes: quotient sign is the XOR of the
        // operand signs, remainder follows the dividend. 0x80000000 / -1
        // falls out as quotient 0x80000000, remainder 0.
        abs_a   = md.A[31] ? (32'd0 - md.A) : md.A;
        abs_b   = divisor_u[31] ? (32'd0 - divisor_u) : divisor_u;
        mag_q   = abs_a / abs_b;
        mag_r   = abs_a % abs_b;
        div_q_s = (md.A[31] ^ divisor_u[31]) ? (32'd0 - mag_q) : mag_q;
        div_r_s = md.A[31] ? (32'd0 - mag_r) : mag_r;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (md.start) begin
                    case (md.md_op)
                        OP_MTHI: hi_d = md.A;
                        OP_MTLO: lo_d = md.A;
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            case (md.md_op)
                                OP_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
                                OP_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
                                OP_MADD:  {pend_hi_d, pend_lo_d} = acc + prod_s;
                                OP_MADDU: {pend_hi_d, pend_lo_d} = acc + prod_u;
                                OP_MSUB:  {pend_hi_d, pend_lo_d} = acc - prod_s;
                                default:  {pend_hi_d, pend_lo_d} = acc - prod_u;
                            endcase
                            cnt_d   = MULT_CNT;
                            state_d = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (md.B == 32'd0) begin
                                // Commit leaves HI/LO as they were.
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                            end else if (md.md_op == OP_DIV) begin
                                pend_hi_d = div_r_s;
                                pend_lo_d = div_q_s;
                            end else begin
                                pend_hi_d = div_r_u;
                                pend_lo_d = div_q_u;
                            end
                            cnt_d   = DIV_CNT;
                            state_d = RUN;
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign md.busy      = (state_q == RUN);
    assign md.HI        = hi_q;
    assign md.LO        = lo_q;
    assign md.dbg_state = state_q;
endmodule
